// File: rtl/lfsr_gen.sv
// lfsr_gen -- parametrised Galois LFSR with seed load, multi-step advance and
// a valid/ready serial drain port (LSB first).
//
// Optional feature macro: LFSR_GEN_DEBRUIJN_EN
//   defined   : feedback is extended so the all-zero state joins the cycle
//               (de Bruijn sequence, period 2^WIDTH); seed 0 is loaded as 0.
//   undefined : plain Galois LFSR; seed 0 is stored as 1 so the register can
//               never lock up in the all-zero state.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   seed_load   in   load seed into the LFSR (highest priority, aborts a drain)
//   seed        in   seed value, WIDTH bits
//   run         in   advance the LFSR by STEPS steps (IDLE only)
//   drain_start in   snapshot the LFSR and start serial drain (IDLE only)
//   out_ready   in   consumer accepts out_bit
//   lfsr        out  current LFSR state
//   out_bit     out  serial bit, LSB first
//   out_valid   out  out_bit valid
//   busy        out  high while draining
//   done        out  one-cycle pulse after the last drained bit is accepted
module lfsr_gen #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'h1D,
  parameter int unsigned      STEPS      = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = 8'h01
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             run,
  input  logic             drain_start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lfsr,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;

  // One Galois step; tap bit 0 is ignored because stage 0 takes the feedback.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    logic             fb;
    logic [WIDTH-1:0] n;
`ifdef LFSR_GEN_DEBRUIJN_EN
    // Inverting feedback when the low stages are all zero splices the
    // all-zero state into the cycle between 10..0 and the tap pattern.
    fb = s[WIDTH-1] ^ ~(|s[WIDTH-2:0]);
`else
    fb = s[WIDTH-1];
`endif
    n[0] = fb;
    for (int i = 1; i < WIDTH; i++) begin
      n[i] = s[i-1] ^ (TAPS[i] & fb);
    end
    return n;
  endfunction

  // STEPS chained steps, all within one clock cycle.
  function automatic logic [WIDTH-1:0] step_n(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
    for (int k = 0; k < STEPS; k++) begin
      v = step1(v);
    end
    return v;
  endfunction

  // Seed conditioning: without the de Bruijn extension zero is a lock-up state.
  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
`ifdef LFSR_GEN_DEBRUIJN_EN
    return s;
`else
    return (s == '0) ? ONE : s;
`endif
  endfunction

  assign accept_s = out_valid_q & out_ready;

  // State register and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= RESET_SEED;
      sh_q        <= '0;
      cnt_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; priority seed_load > drain_start > run.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_d = seed_fix(seed);
        end else if (drain_start) begin
          sh_d        = lfsr_q;
          cnt_d       = '0;
          out_bit_d   = lfsr_q[0];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_DRAIN;
        end else if (run) begin
          lfsr_d = step_n(lfsr_q);
        end else begin
          lfsr_d = lfsr_q;
        end
      end
      ST_DRAIN: begin
        if (accept_s && (cnt_q == LAST_IDX)) begin
          // Final bit accepted: done pulses even if a load arrives together
          // with it; the load then takes effect on the same edge.
          sh_d        = '0;
          cnt_d       = '0;
          out_bit_d   = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
          if (seed_load) begin
            lfsr_d = seed_fix(seed);
          end else begin
            lfsr_d = lfsr_q;
          end
        end else if (seed_load) begin
          // Abort: the remaining bits are dropped and no done is signalled.
          lfsr_d      = seed_fix(seed);
          out_bit_d   = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (accept_s) begin
          sh_d      = sh_q >> 1;
          cnt_d     = cnt_q + CW'(1);
          out_bit_d = sh_q[1];
        end else begin
          // Stalled: hold bit and valid so nothing is lost or repeated.
          out_bit_d = out_bit_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign lfsr      = lfsr_q;
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
